adder_result_stage: RTL and testbench

- Registered output stage directly downstream of the 64-bit ripple adder and the two-stage carry-select adder.
- Captures both adders' sum/carry results with their operands and computes status flags (Z, N, C, V).
- Cross-checks the two adder results against each other and keeps mismatch and transaction counters.
- Buffers results in a 2-entry skid FIFO behind a valid/ready handshake toward the consumer.

---
 rtl/adder_result_stage.sv | 138 +++++++++++++
 tb/tb_adder_result_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_stage.sv
// adder_result_stage: registered result stage behind the ripple and
// carry-select adders. It captures the primary (ripple) result, computes
// the Z/N/C/V status flags and cross-checks the two adders. Results are
// held in a 2-entry FIFO with a valid/ready handshake, and the stage keeps
// saturating counters of transactions and mismatches.
// Optional build macro ADDER_GOLDEN_CHECK_EN adds an internal reference
// adder, so that mismatch also flags both adders being wrong identically.
module adder_result_stage #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] sum_r,
    input  logic             cout_r,
    input  logic [WIDTH-1:0] sum_cs,
    input  logic             cout_cs,
    input  logic             clr_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [3:0]       out_flags,
    output logic             out_mismatch,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t occ_q, occ_d;

    logic             wr_ptr, rd_ptr;
    logic [WIDTH-1:0] sum_mem   [2];
    logic             cout_mem  [2];
    logic [3:0]       flags_mem [2];
    logic             mm_mem    [2];

    logic       push, pop;
    logic [3:0] flags_new;
    logic       mismatch_new;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Ready and valid come straight from the occupancy register, so there
    // is no combinational path from out_ready to in_ready.
    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Z, N, C and V are taken from the primary (ripple) result.
    assign flags_new = {(sum_r == '0),
                        sum_r[WIDTH-1],
                        cout_r,
                        (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_r[WIDTH-1] != in_a[WIDTH-1])};

`ifdef ADDER_GOLDEN_CHECK_EN
    logic [WIDTH:0] gold;
    assign gold = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
    assign mismatch_new = (sum_r != sum_cs) || (cout_r != cout_cs) ||
                          ({cout_r, sum_r} != gold);
`else
    // Without the reference adder the carry-in and low operand bits are
    // not needed; only the operand MSBs feed the overflow flag.
    logic unused_operands;
    assign unused_operands = ^{in_cin, in_a[WIDTH-2:0], in_b[WIDTH-2:0]};
    assign mismatch_new = (sum_r != sum_cs) || (cout_r != cout_cs);
`endif

    // Next occupancy from push/pop; a simultaneous push and pop holds it.
    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            EMPTY:   if (push) occ_d = ONE;
            ONE:     if (push && !pop) occ_d = FULL;
                     else if (pop && !push) occ_d = EMPTY;
            FULL:    if (pop) occ_d = ONE;
            default: occ_d = EMPTY;
        endcase
    end

    // Occupancy register; reset drops all buffered entries immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) occ_q <= EMPTY;
        else        occ_q <= occ_d;
    end

    // Write and read pointers of the two-slot buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Entry storage; data only, validity is tracked by the occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            sum_mem[wr_ptr]   <= sum_r;
            cout_mem[wr_ptr]  <= cout_r;
            flags_mem[wr_ptr] <= flags_new;
            mm_mem[wr_ptr]    <= mismatch_new;
        end
    end

    // Head outputs read zero whenever the buffer is empty (including reset).
    assign out_sum      = out_valid ? sum_mem[rd_ptr]   : '0;
    assign out_cout     = out_valid ? cout_mem[rd_ptr]  : 1'b0;
    assign out_flags    = out_valid ? flags_mem[rd_ptr] : 4'd0;
    assign out_mismatch = out_valid ? mm_mem[rd_ptr]    : 1'b0;

    // Saturating counters; a clear beats an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            txn_cnt      <= '0;
            mismatch_cnt <= '0;
        end else if (push) begin
            txn_cnt <= sat_inc(txn_cnt);
            if (mismatch_new) mismatch_cnt <= sat_inc(mismatch_cnt);
        end
    end

endmodule

// File: tb/tb_adder_result_stage.sv
// Testbench for adder_result_stage: directed cases plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_adder_result_stage;

    localparam int W  = 64;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, in_cin, cout_r, cout_cs, clr_cnt;
    logic [W-1:0]  in_a, in_b, sum_r, sum_cs, out_sum;
    logic          out_valid, out_ready, out_cout, out_mismatch;
    logic [3:0]    out_flags;
    logic [CW-1:0] txn_cnt, mismatch_cnt;

    adder_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .sum_r(sum_r), .cout_r(cout_r),
        .sum_cs(sum_cs), .cout_cs(cout_cs), .clr_cnt(clr_cnt), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_flags(out_flags), .out_mismatch(out_mismatch), .txn_cnt(txn_cnt),
        .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic [3:0]   flags;
        logic         mm;
    } ent_t;

    ent_t          mq[$];
    int            m_txn, m_mm;
    bit            live = 0;
    int            vectors = 0;
    int            miscompares = 0;

`ifdef ADDER_GOLDEN_CHECK_EN
    localparam bit GOLDEN = 1'b1;
`else
    localparam bit GOLDEN = 1'b0;
`endif

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t model_entry(input logic [W-1:0] a, b, input logic cin,
                                         input logic [W-1:0] sr, input logic cr,
                                         input logic [W-1:0] scs, input logic ccs);
        ent_t e;
        logic [W:0] ref_sum;
        bit sa, sb, ss;
        sa = $signed(a) < 0;
        sb = $signed(b) < 0;
        ss = $signed(sr) < 0;
        e.sum   = sr;
        e.cout  = cr;
        e.flags = {sr == 0, ss, cr, (sa == sb) && (ss != sa)};
        ref_sum = W'(a) + W'(b) + cin;  // widened below
        ref_sum = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        e.mm    = (sr != scs) || (cr != ccs) || (GOLDEN && ({cr, sr} != ref_sum));
        return e;
    endfunction

    // Reference model: advances on every rising edge from the same inputs.
    always @(posedge clk) begin
        bit do_push, do_pop;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_txn = 0;
            m_mm  = 0;
            live  = 1;
        end else if (live) begin
            do_push = in_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && out_ready;
            e = model_entry(in_a, in_b, in_cin, sum_r, cout_r, sum_cs, cout_cs);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
            if (clr_cnt) begin
                m_txn = 0;
                m_mm  = 0;
            end else if (do_push) begin
                if (m_txn < CMAX) m_txn++;
                if (e.mm && m_mm < CMAX) m_mm++;
            end
        end
    end

    // Compare process: checks the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (live) begin
            check("in_ready", in_ready, mq.size() < 2);
            check("out_valid", out_valid, mq.size() > 0);
            check("txn_cnt", txn_cnt, m_txn);
            check("mismatch_cnt", mismatch_cnt, m_mm);
            if (mq.size() > 0) begin
                check("out_sum", out_sum, mq[0].sum);
                check("out_cout", out_cout, mq[0].cout);
                check("out_flags", out_flags, mq[0].flags);
                check("out_mismatch", out_mismatch, mq[0].mm);
            end
        end
    end

    task automatic set_in(input logic [W-1:0] a, b, input logic cin,
                          input logic [W-1:0] sr, input logic cr,
                          input logic [W-1:0] scs, input logic ccs);
        in_a = a; in_b = b; in_cin = cin;
        sum_r = sr; cout_r = cr; sum_cs = scs; cout_cs = ccs;
    endtask

    task automatic set_good(input logic [W-1:0] a, b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        set_in(a, b, 1'b0, s[W-1:0], s[W], s[W-1:0], s[W]);
    endtask

    // Present one result and hold it until accepted (bounded wait).
    task automatic push_one(input logic [W-1:0] a, b, input logic cin,
                            input logic [W-1:0] sr, input logic cr,
                            input logic [W-1:0] scs, input logic ccs);
        int n;
        n = 0;
        @(negedge clk);
        set_in(a, b, cin, sr, cr, scs, ccs);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        set_in('0, '0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_flags", out_flags, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_txn", txn_cnt, 0);

        // Carry case
        push_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h1, 1'b1, 64'h1, 1'b1);
        check("carry_sum", out_sum, 64'h1);
        check("carry_cout", out_cout, 1);
        check("carry_flags", out_flags, 4'b0010);
        check("carry_mm", out_mismatch, 0);
        check("carry_txn", txn_cnt, 1);

        // Overflow and zero
        push_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0);
        check("ovf_flags", out_flags, 4'b0101);
        push_one('0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        check("zero_flags", out_flags, 4'b1000);

        // Disagreement between the adders
        push_one(64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 64'h3, 1'b0);
        check("dis_mm", out_mismatch, 1);
        check("dis_mmcnt", mismatch_cnt, 1);
        push_one(64'h1, 64'h1, 1'b0, 64'h3, 1'b0, 64'h3, 1'b0);
        check("same_wrong_mm", out_mismatch, GOLDEN);

        // Backpressure: three results, two slots
        @(negedge clk);
        out_ready = 1'b0;
        set_good(64'h10, 64'h1); in_valid = 1'b1;
        @(negedge clk);
        set_good(64'h20, 64'h2);
        @(negedge clk);
        check("bp_full_ready", in_ready, 0);
        set_good(64'h30, 64'h3);
        @(negedge clk);
        check("bp_head0", out_sum, 64'h11);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_back", in_ready, 1);
        check("bp_head1", out_sum, 64'h22);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_head2", out_sum, 64'h33);
        @(negedge clk);

        // Clear has priority over a counted push
        set_good(64'h5, 64'h6); in_valid = 1'b1; clr_cnt = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr_cnt = 1'b0;
        check("clr_txn", txn_cnt, 0);
        check("clr_mm", mismatch_cnt, 0);

        // Reset while full
        out_ready = 1'b0;
        set_good(64'h7, 64'h8); in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstfull_valid", out_valid, 0);
        check("rstfull_ready", in_ready, 1);

        // Randomized traffic, long enough to saturate the counters
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] a, b, sr, scs;
            logic cin, cr, ccs;
            logic [W:0] s;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = '0;
            if ($urandom_range(0, 7) == 0) b = ~a;
            cin = $urandom_range(0, 1);
            s = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
            sr = s[W-1:0];
            cr = s[W];
            if ($urandom_range(0, 9) == 0) sr = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) cr = ~cr;
            scs = sr;
            ccs = cr;
            if ($urandom_range(0, 9) == 0) scs = sr ^ (64'h1 << $urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) ccs = ~cr;
            set_in(a, b, cin, sr, cr, scs, ccs);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clr_cnt   = ($urandom_range(0, 299) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0; clr_cnt = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
